// File: rtl/regfile_pkg.sv
// Shared defaults, port limits and packing helpers for the multiport register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_READ   = 2;
  localparam int DEF_NUM_WRITE  = 2;
  localparam int DEF_ZERO_REG   = 1;

  localparam int MIN_NUM_READ   = 1;
  localparam int MAX_NUM_READ   = 4;
  localparam int MIN_NUM_WRITE  = 1;
  localparam int MAX_NUM_WRITE  = 2;

  // Low bit of slice idx in a bus packing equal-width fields, slice 0 in the LSBs.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve sets, any enabled write clears, reserve wins a tie.
// busy is the registered state; busy_next is the same-cycle update used for read readiness.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WRITE-1:0]            write_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr,
  input  logic                            reserve_en,
  input  logic [ADDR_WIDTH-1:0]           reserve_addr,
  output logic [2**ADDR_WIDTH-1:0]        busy,
  output logic [2**ADDR_WIDTH-1:0]        busy_next
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (reserve_en) begin
      set_mask[reserve_addr] = 1'b1;
    end
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (write_en[w]) begin
        clr_mask[write_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
    // Set is applied after clear so a same-edge reserve keeps the register busy.
    busy_next = (busy & ~clr_mask) | set_mask;
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Flop-array register file with NUM_WRITE write ports, NUM_READ registered read ports and busy scoreboard.
// Reads take one cycle and see same-edge writes (higher write port wins); no backpressure.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   ReadAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   ReadData,
  output logic [NUM_READ-1:0]              ReadReady,
  input  logic [NUM_WRITE-1:0]             WriteEnable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  WriteAddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  WriteData,
  input  logic                             ReserveEnable,
  input  logic [ADDR_WIDTH-1:0]            ReserveAddr,
  output logic [2**ADDR_WIDTH-1:0]         BusyVector
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  if (NUM_READ < MIN_NUM_READ || NUM_READ > MAX_NUM_READ) begin : g_bad_num_read
    $error("multiport_register_file: NUM_READ out of range");
  end
  if (NUM_WRITE < MIN_NUM_WRITE || NUM_WRITE > MAX_NUM_WRITE) begin : g_bad_num_write
    $error("multiport_register_file: NUM_WRITE out of range");
  end

  logic [DATA_WIDTH-1:0] regs      [DEPTH];
  logic [DATA_WIDTH-1:0] regs_next [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr   [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wr_data   [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] rd_addr   [NUM_READ];
  logic [DEPTH-1:0]      busy_next;

  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_addr[w] = WriteAddr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH];
      wr_data[w] = WriteData[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
    end
    for (int p = 0; p < NUM_READ; p++) begin
      rd_addr[p] = ReadAddr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
    end
  end

  // Ascending port scan: the last matching port overrides, so the highest index wins a conflict.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_next[i] = regs[i];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (WriteEnable[w] && (wr_addr[w] == ADDR_WIDTH'(i))) begin
          regs_next[i] = wr_data[w];
        end
      end
      if (ZERO_REG != 0 && i == 0) begin
        regs_next[i] = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= regs_next[i];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .write_en     (WriteEnable),
    .write_addr   (WriteAddr),
    .reserve_en   (ReserveEnable),
    .reserve_addr (ReserveAddr),
    .busy         (BusyVector),
    .busy_next    (busy_next)
  );

  // Reading the next-state array and busy bits gives write-through data and matching readiness.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ReadData  <= '0;
      ReadReady <= '0;
    end else begin
      for (int p = 0; p < NUM_READ; p++) begin
        ReadData[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] <= regs_next[rd_addr[p]];
        ReadReady[p] <= ~busy_next[rd_addr[p]];
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file at default parameters (32b x 32, 2R/2W, zero register).
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic                clk;
  logic                rst_n;
  logic [NR*AW-1:0]    read_addr;
  logic [NR*DW-1:0]    read_data;
  logic [NR-1:0]       read_ready;
  logic [NW-1:0]       write_enable;
  logic [NW*AW-1:0]    write_addr;
  logic [NW*DW-1:0]    write_data;
  logic                reserve_enable;
  logic [AW-1:0]       reserve_addr;
  logic [2**AW-1:0]    busy_vector;

  int tests;
  int fails;

  multiport_register_file dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .ReadAddr      (read_addr),
    .ReadData      (read_data),
    .ReadReady     (read_ready),
    .WriteEnable   (write_enable),
    .WriteAddr     (write_addr),
    .WriteData     (write_data),
    .ReserveEnable (reserve_enable),
    .ReserveAddr   (reserve_addr),
    .BusyVector    (busy_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable   = '0;
    write_addr     = '0;
    write_data     = '0;
    reserve_enable = 1'b0;
    reserve_addr   = '0;
  endtask

  task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_addr = {a1, a0};
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable[port]          = 1'b1;
    write_addr[port*AW +: AW]   = a;
    write_data[port*DW +: DW]   = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    reserve_enable = 1'b1;
    reserve_addr   = a;
  endtask

  task automatic chk_read(input string name, input logic [DW-1:0] exp0, input logic [DW-1:0] exp1,
                          input logic [1:0] exp_rdy);
    tests++;
    if (read_data !== {exp1, exp0} || read_ready !== exp_rdy) begin
      fails++;
      $display("FAIL %s: data=%h ready=%b, expected data=%h ready=%b",
               name, read_data, read_ready, {exp1, exp0}, exp_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_reads(5'd0, 5'd0);
    repeat (3) tick();
    chk_read("reset_outputs", 32'h0, 32'h0, 2'b00);
    tests++;
    if (busy_vector !== 32'h0) begin
      fails++;
      $display("FAIL reset_busy: got %h expected %h", busy_vector, 32'h0);
    end
    rst_n = 1'b1;
    #2;
    chk_read("ready_before_first_edge", 32'h0, 32'h0, 2'b00);
    tick();
  endtask

  task automatic test_write_read();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    set_reads(5'd1, 5'd1);
    tick();
    idle();
    set_reads(5'd5, 5'd5);
    tick();
    chk_read("write_then_read_r5_both_ports", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11);
  endtask

  task automatic test_bypass();
    wr(0, 5'd7, 32'h0000_1234);
    set_reads(5'd7, 5'd5);
    tick();
    idle();
    chk_read("bypass_r7", 32'h0000_1234, 32'hDEAD_BEEF, 2'b11);
  endtask

  task automatic test_conflict();
    wr(0, 5'd3, 32'h0000_AAAA);
    wr(1, 5'd3, 32'h0000_5555);
    set_reads(5'd3, 5'd7);
    tick();
    idle();
    chk_read("conflict_bypass_r3", 32'h0000_5555, 32'h0000_1234, 2'b11);
    tick();
    chk_read("conflict_stored_r3", 32'h0000_5555, 32'h0000_1234, 2'b11);
  endtask

  task automatic test_write_disable();
    write_enable = 2'b00;
    write_addr   = {5'd5, 5'd5};
    write_data   = {32'h0, 32'h0};
    set_reads(5'd5, 5'd3);
    tick();
    tick();
    idle();
    chk_read("disabled_write_holds", 32'hDEAD_BEEF, 32'h0000_5555, 2'b11);
  endtask

  task automatic test_zero_reg();
    wr(1, 5'd0, 32'h0000_FFFF);
    rsv(5'd0);
    set_reads(5'd0, 5'd0);
    tick();
    idle();
    chk_read("zero_reg_read", 32'h0, 32'h0, 2'b11);
    tests++;
    if (busy_vector[0] !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg_busy: got %b expected 0", busy_vector[0]);
    end
  endtask

  task automatic test_reserve();
    rsv(5'd9);
    set_reads(5'd9, 5'd5);
    tick();
    idle();
    chk_read("reserve_read_same_edge", 32'h0, 32'hDEAD_BEEF, 2'b10);
    tests++;
    if (busy_vector !== 32'h0000_0200) begin
      fails++;
      $display("FAIL reserve_busy_r9: got %h expected %h", busy_vector, 32'h0000_0200);
    end
    rsv(5'd9);
    tick();
    idle();
    chk_read("reserve_twice_still_busy", 32'h0, 32'hDEAD_BEEF, 2'b10);
    wr(1, 5'd9, 32'h0000_0042);
    tick();
    idle();
    chk_read("write_clears_busy_r9", 32'h0000_0042, 32'hDEAD_BEEF, 2'b11);
    tests++;
    if (busy_vector !== 32'h0) begin
      fails++;
      $display("FAIL busy_cleared_r9: got %h expected %h", busy_vector, 32'h0);
    end
    rsv(5'd9);
    wr(0, 5'd9, 32'h0000_0099);
    tick();
    idle();
    chk_read("reserve_and_write_r9", 32'h0000_0099, 32'hDEAD_BEEF, 2'b10);
    tests++;
    if (busy_vector !== 32'h0000_0200) begin
      fails++;
      $display("FAIL reserve_wins_r9: got %h expected %h", busy_vector, 32'h0000_0200);
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 5'd4, 32'h0000_0077);
    rsv(5'd4);
    set_reads(5'd4, 5'd9);
    tick();
    idle();
    chk_read("r4_before_reset", 32'h0000_0077, 32'h0000_0099, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_read("async_reset_outputs", 32'h0, 32'h0, 2'b00);
    tests++;
    if (busy_vector !== 32'h0) begin
      fails++;
      $display("FAIL async_reset_busy: got %h expected %h", busy_vector, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_reads(5'd4, 5'd5);
    tick();
    chk_read("after_reset_r4_r5", 32'h0, 32'h0, 2'b11);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    read_addr = '0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_write_disable();
    test_zero_reg();
    test_reserve();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_WIDTH, 32, bits per register.
REQ-002 Parameter ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter NUM_READ, 2, read ports (1..4).
REQ-004 Parameter NUM_WRITE, 2, write ports (1..2).
REQ-005 Parameter ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes and reserves.
REQ-006 Clk  input  1  single clock; all state on rising edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 ReadAddr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port p occupies slice p.
REQ-009 ReadData  output  NUM_READ*DATA_WIDTH  registered read data, packed like ReadAddr.
REQ-010 ReadReady  output  NUM_READ  registered flag: the addressed register had no pending reservation.
REQ-011 WriteEnable  input  NUM_WRITE  per-port write strobe.
REQ-012 WriteAddr  input  NUM_WRITE*ADDR_WIDTH  packed write addresses.
REQ-013 WriteData  input  NUM_WRITE*DATA_WIDTH  packed write data.
REQ-014 ReserveEnable  input  1  marks ReserveAddr busy (pending producer).
REQ-015 ReserveAddr  input  ADDR_WIDTH  register to reserve.
REQ-016 BusyVector  output  DEPTH  current busy bits, bit i = register i.

Function
REQ-017 Reads have 1-cycle latency: ReadData[p] at edge N+1 reflects ReadAddr[p] sampled at edge N.
REQ-018 Write-through: a write committed at edge N to the address read at edge N appears on ReadData at N+1 (new data, not old).
REQ-019 Write conflict (both ports enabled, same address): the higher-index port's data is stored and bypassed.
REQ-020 Writes with WriteEnable low have no effect; the array holds its value.
REQ-021 ZERO_REG=1: reads of address 0 return 0 and ReadReady=1 regardless of writes or reserves.
REQ-022 Busy set: ReserveEnable at edge N sets busy[ReserveAddr] from N onward.
REQ-023 Busy clear: any enabled write to address a at edge N clears busy[a].
REQ-024 Simultaneous reserve and write to the same address: reserve wins, busy ends at 1, data still written.
REQ-025 Reserving an already busy register keeps it busy (no counting).
REQ-026 ReadReady[p] at N+1 = NOT busy[ReadAddr[p]] after the edge-N busy update (consistent with the bypassed data).
REQ-027 Multiple read ports addressing the same register return identical data and ready.
REQ-028 Out-of-range addresses are impossible (DEPTH = 2**ADDR_WIDTH); no wrap logic is needed.

Reset
REQ-029 Reset_n low asynchronously clears all registers, all busy bits, ReadData and ReadReady to 0.
REQ-030 Reset takes priority over any same-cycle write or reserve; the first operation after deassertion is the first rising edge with Reset_n high.
REQ-031 ReadReady resets to 0 and becomes valid at the first post-reset read edge.

Structure
REQ-032 Default widths, port limits and packing-slice helper constants live in shared package regfile_pkg.
REQ-033 One sub-module, regfile_scoreboard, holds the busy bits and the reserve/clear priority logic; storage, write arbitration and bypass stay in the top.
REQ-034 Storage is a flop array (async reset required); no memory macro.

Verification
REQ-035 Reset, then write r5=0xDEADBEEF on port 0, read r5 the next cycle -> ReadData=0xDEADBEEF, ReadReady=1.
REQ-036 Same edge: write r7=0x1234 and read r7 -> at N+1 ReadData=0x1234 (bypass, not 0).
REQ-037 Port 0 writes r3=0xAAAA and port 1 writes r3=0x5555 on the same edge -> r3 reads 0x5555.
REQ-038 Write r0=0xFFFF, reserve r0, read r0 -> ReadData=0, ReadReady=1, BusyVector[0]=0.
REQ-039 Reserve r9; read r9 -> ReadReady=0; write r9=0x42 -> next read ReadReady=1, data 0x42; reserve and write r9 on the same edge -> BusyVector[9]=1.
REQ-040 Write r4=0x77 and reserve r4, then pull Reset_n low mid-cycle -> all outputs 0 immediately; after release r4 reads 0, ReadReady=1.
